// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: shared FSM state type and byte geometry for the FIFO-draining UART transmitter
package fifo_uart_pkg;
  localparam int BYTE_BITS = 8;
  localparam int BYTES_PER_WORD = 2;
  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: per-bit down-counter; load reloads CLKS_PER_BIT-1, tick is high while the count sits at 0
//   clk, rst (async active-low), load -> tick
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic tick
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  logic [TW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? TW'(CLKS_PER_BIT - 1) : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign tick = (cnt_q == '0);
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops 16-bit FIFO words and sends each as two 8N1 frames, low byte first
//   clk, rst (async active-low), fifo_empty, fifo_data -> fifo_rd_en, tx, busy, word_cnt
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_cnt
);
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [2:0] idx_q, idx_d;
  logic byte_sel_q, byte_sel_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d;
  logic rd_en_q, rd_en_d;
  logic load, tick;
  logic [BYTE_BITS-1:0] cur_byte;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk (clk),
    .rst (rst),
    .load(load),
    .tick(tick)
  );

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    idx_d      = idx_q;
    byte_sel_d = byte_sel_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    rd_en_d    = 1'b0;
    load       = 1'b0;
    case (state_q)
      // rd_en and busy are registered, so both are set on the edge entering POP
      IDLE: if (!fifo_empty) begin
        state_d = POP;
        rd_en_d = 1'b1;
        busy_d  = 1'b1;
      end
      POP: state_d = LOAD;
      // arming the timer here makes the start bit last exactly CLKS_PER_BIT cycles
      LOAD: begin
        hold_d     = fifo_data;
        byte_sel_d = 1'b0;
        load       = 1'b1;
        state_d    = START;
      end
      START: if (tick) begin
        load    = 1'b1;
        idx_d   = '0;
        state_d = DATA;
      end
      DATA: if (tick) begin
        load    = 1'b1;
        idx_d   = idx_q + 1'b1;
        state_d = (idx_q == 3'(BYTE_BITS - 1)) ? STOP : DATA;
      end
      STOP: if (tick) begin
        load = 1'b1;
        if (byte_sel_q == 1'(BYTES_PER_WORD - 1)) begin
          cnt_d   = cnt_q + 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          byte_sel_d = 1'b1;
          state_d    = START;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      idx_q      <= '0;
      byte_sel_q <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      rd_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      idx_q      <= idx_d;
      byte_sel_q <= byte_sel_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      rd_en_q    <= rd_en_d;
    end

  // tx decodes straight from the state register so an async reset drives the line high at once
  assign cur_byte   = byte_sel_q ? hold_q[2*BYTE_BITS-1:BYTE_BITS] : hold_q[BYTE_BITS-1:0];
  assign tx         = (state_q == START) ? 1'b0 : (state_q == DATA) ? cur_byte[idx_q] : 1'b1;
  assign fifo_rd_en = rd_en_q;
  assign busy       = busy_q;
  assign word_cnt   = cnt_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: scoreboard bench; a FIFO model feeds words, a line receiver checks every tx cycle
module tb_fifo_uart_tx;
  localparam int CPB = 4;
  localparam int WORD_CYC = 20 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic fifo_empty = 1'b1;
  logic [15:0] fifo_data = '0;
  logic fifo_rd_en, tx, busy;
  logic [15:0] word_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int last_pop = 0;
  int pop_cyc[$];
  logic [15:0] fifo[$];
  logic [15:0] exp_q[$];
  logic [15:0] exp_cnt = '0;
  logic hold_off = 1'b0;
  logic rx_on = 1'b0;
  int rx_c = 0;
  logic [15:0] rx_w = '0;

  fifo_uart_tx #(.DATA_WIDTH(16), .CLKS_PER_BIT(CPB), .CNT_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .tx        (tx),
    .busy      (busy),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic exp_bit(input logic [15:0] w, input int c);
    int b = (c % 40) / 4;
    logic [7:0] by = (c >= 40) ? w[15:8] : w[7:0];
    return (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : by[b-1];
  endfunction

  // FIFO model: registered data on the cycle after a pop, registered empty flag
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fifo.size() != 0) fifo_data <= fifo.pop_front();
      else fifo_data <= 'x;
    end
    fifo_empty <= hold_off || (fifo.size() == 0);
  end

  always @(negedge clk)
    if (rst && fifo_rd_en) begin
      pop_cnt++;
      last_pop = cyc;
      pop_cyc.push_back(cyc);
      chk("rd_while_empty", {31'b0, fifo_empty}, 0);
    end

  // line receiver: compares every cycle of both frames against the scoreboard head
  always @(negedge clk) begin
    if (!rst) rx_on = 1'b0;
    else begin
      if (!rx_on && tx === 1'b0) begin
        chk("sb_has_word", {31'b0, exp_q.size() != 0}, 1);
        rx_w  = (exp_q.size() != 0) ? exp_q[0] : 16'h0;
        rx_on = 1'b1;
        rx_c  = 0;
        chk("start_latency", cyc - last_pop, 2);
        chk("busy_in_frame", {31'b0, busy}, 1);
      end
      if (rx_on) begin
        if (rx_c < WORD_CYC) chk($sformatf("tx_c%0d", rx_c), {31'b0, tx}, {31'b0, exp_bit(rx_w, rx_c)});
        else begin
          chk("word_cnt", {16'b0, word_cnt}, {16'b0, exp_cnt});
          chk("busy_after", {31'b0, busy}, 0);
          rx_on = 1'b0;
        end
        if (rx_c == WORD_CYC - 1) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          exp_cnt = exp_cnt + 1'b1;
        end
        rx_c++;
      end
    end
  end

  task automatic push(input logic [15:0] w);
    fifo.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic wait_pops(input int n, input int max);
    int i;
    for (i = 0; i < max && pop_cnt < n; i++) @(negedge clk);
    if (pop_cnt < n) chk("pop_timeout", pop_cnt, n);
  endtask

  task automatic wait_done(input int max);
    int i;
    for (i = 0; i < max && (exp_q.size() != 0 || busy || rx_on); i++) @(negedge clk);
    if (exp_q.size() != 0 || busy) chk("done_timeout", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'b0, tx}, 1);
    chk("rst_rd_en", {31'b0, fifo_rd_en}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_word_cnt", {16'b0, word_cnt}, 0);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    chk("idle_no_pop", pop_cnt, 0);
    chk("idle_tx", {31'b0, tx}, 1);

    push(16'hA55A);
    wait_done(300);
    chk("single_pops", pop_cnt, 1);
    chk("single_cnt", {16'b0, word_cnt}, 1);

    pop_cyc.delete();
    push(16'h0001);
    push(16'hFFFF);
    wait_done(400);
    chk("b2b_pops", pop_cyc.size(), 2);
    if (pop_cyc.size() >= 2) chk("b2b_gap", pop_cyc[1] - pop_cyc[0], 83);
    chk("b2b_cnt", {16'b0, word_cnt}, 3);

    base = pop_cnt;
    push(16'h0F0F);
    push(16'h8001);
    wait_pops(base + 1, 200);
    repeat (10) @(negedge clk);
    hold_off = 1'b1;
    repeat (180) @(negedge clk);
    chk("empty_pops", pop_cnt, base + 1);
    chk("empty_tx", {31'b0, tx}, 1);
    chk("empty_busy", {31'b0, busy}, 0);
    chk("empty_left", exp_q.size(), 1);
    chk("empty_cnt", {16'b0, word_cnt}, 4);
    hold_off = 1'b0;
    wait_done(300);
    chk("resume_cnt", {16'b0, word_cnt}, 5);

    base = pop_cnt;
    push(16'h1234);
    wait_pops(base + 1, 200);
    repeat (19) @(negedge clk);
    chk("tx_bit3_low", {31'b0, tx}, 0);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_tx", {31'b0, tx}, 1);
    chk("async_rst_busy", {31'b0, busy}, 0);
    chk("async_rst_cnt", {16'b0, word_cnt}, 0);
    void'(exp_q.pop_front());
    exp_cnt = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    push(16'hC3E1);
    wait_done(300);
    chk("post_rst_cnt", {16'b0, word_cnt}, 1);

    force dut.cnt_q = 16'hFFFF;
    @(posedge clk);
    #1 release dut.cnt_q;
    exp_cnt = 16'hFFFF;
    @(negedge clk);
    chk("preload_cnt", {16'b0, word_cnt}, 32'hFFFF);
    push(16'h5AA5);
    wait_done(300);
    chk("wrap_cnt", {16'b0, word_cnt}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
